// File: rtl/actividad_05_pkg.sv
// Shared width, opcode encoding and a helper for the actividad_05 ALU.
// The multiplier is built only when ACTIVIDAD_05_MUL_EN is defined.
package actividad_05_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_NAND = 3'b100,
    OP_MUL  = 3'b111
  } op_e;

  // 101 and 110 are never valid; 111 is valid only with the multiplier built in.
  function automatic logic op_valid(input logic [2:0] sel);
    case (sel)
      3'b101, 3'b110: op_valid = 1'b0;
`ifdef ACTIVIDAD_05_MUL_EN
      3'b111:         op_valid = 1'b1;
`else
      3'b111:         op_valid = 1'b0;
`endif
      default:        op_valid = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/actividad_05_core.sv
// Combinational operation decode, result selection and enable gating.
// ACTIVIDAD_05_MUL_EN selects whether the multiplier path exists.
module actividad_05_core
  import actividad_05_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        sel,
  input  logic              enable,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] op_res;

  always_comb begin
    op_res = '0;
    case (sel)
      OP_AND:  op_res = a & b;
      OP_OR:   op_res = a | b;
      OP_ADD:  op_res = a + b;
      OP_SUB:  op_res = a - b;
      OP_NAND: op_res = ~(a & b);
`ifdef ACTIVIDAD_05_MUL_EN
      OP_MUL:  op_res = a * b;
`endif
      default: op_res = '0;
    endcase
  end

  // Invalid codes and a low enable both collapse to zero.
  assign result = (enable && op_valid(sel)) ? op_res : '0;

endmodule

// File: rtl/actividad_05.sv
// Registered 32-bit ALU: the core result is captured every rising clk edge.
// Build with ACTIVIDAD_05_MUL_EN to include the multiplier (sel = 111).
module actividad_05
  import actividad_05_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        sel,
  input  logic              enable,
  output logic [DATA_W-1:0] salida
);

  logic [DATA_W-1:0] result;

  actividad_05_core u_core (
    .a      (a),
    .b      (b),
    .sel    (sel),
    .enable (enable),
    .result (result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) salida <= '0;
    else     salida <= result;
  end

endmodule

// File: tb/tb_actividad_05.sv
// Self-checking bench for actividad_05: directed plan steps plus randomized
// operations checked against an arithmetic reference model.
module tb_actividad_05;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic [2:0]  sel;
  logic        enable;
  logic [31:0] salida;

  int checks   = 0;
  int failures = 0;

  actividad_05 dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .sel    (sel),
    .enable (enable),
    .salida (salida)
  );

  always #5 clk = ~clk;

`ifdef ACTIVIDAD_05_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  // Reference model using 64-bit integer arithmetic reduced modulo 2^32.
  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic [2:0] s, input logic en);
    longint unsigned ux, uy, m;
    ux = longint'(x);
    uy = longint'(y);
    m  = 64'd1 << 32;
    if (!en) return 32'd0;
    case (s)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return 32'((ux + uy) % m);
      3'd3: return 32'((ux + m - uy) % m);
      3'd4: return ~(x & y);
      3'd7: return MUL_ON ? 32'((ux * uy) % m) : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive inputs away from the edge, then sample 1 time unit after the next rising edge.
  task automatic step(input logic [31:0] x, input logic [31:0] y, input logic [2:0] s,
                      input logic en);
    @(negedge clk);
    a = x; b = y; sel = s; enable = en;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ra, rb, held;
    logic [2:0]  rs;
    logic        re;

    rst = 1'b1; a = '0; b = '0; sel = '0; enable = 1'b0;
    #12;
    check("reset_state", salida, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Logic operations
    step(32'd4201, 32'd6669, 3'b000, 1'b1); check("and",  salida, 32'd4105);
    step(32'd4201, 32'd6669, 3'b001, 1'b1); check("or",   salida, 32'd6765);
    step(32'd4201, 32'd6669, 3'b100, 1'b1); check("nand", salida, 32'hFFFF_EFF6);

    // Arithmetic
    step(32'd8, 32'd16, 3'b010, 1'b1); check("add", salida, 32'd24);
    step(32'd8, 32'd16, 3'b011, 1'b1); check("sub", salida, 32'hFFFF_FFF8);
    step(32'd8, 32'd16, 3'b111, 1'b1); check("mul", salida, MUL_ON ? 32'd128 : 32'd0);

    // Invalid codes
    step(32'd8, 32'd16, 3'b110, 1'b1); check("inv110", salida, 32'd0);
    step(32'd8, 32'd16, 3'b101, 1'b1); check("inv101", salida, 32'd0);

    // Enable gating
    step(32'd8, 32'd16, 3'b010, 1'b0); check("en_low", salida, 32'd0);
    step(32'd8, 32'd16, 3'b010, 1'b1); check("en_back", salida, 32'd24);

    // Input change between edges does not reach the output before the edge
    @(negedge clk);
    a = 32'd100; sel = 3'b001;
    #1;
    check("hold_between_edges", salida, 32'd24);
    @(posedge clk); #1;
    check("after_edge", salida, 32'd116);

    // Wrap-around
    step(32'hFFFF_FFFF, 32'd1, 3'b010, 1'b1); check("add_wrap", salida, 32'd0);
    step(32'h0001_0000, 32'h0001_0000, 3'b111, 1'b1); check("mul_wrap", salida, 32'd0);

    // Async reset mid-cycle
    step(32'd8, 32'd16, 3'b010, 1'b1); check("pre_reset", salida, 32'd24);
    #2;
    rst = 1'b1;
    #1;
    check("reset_immediate", salida, 32'd0);
    @(posedge clk); #1;
    check("reset_held", salida, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_no_edge", salida, 32'd0);
    @(posedge clk); #1;
    check("first_after_release", salida, 32'd24);

    // Randomized operations against the model
    for (int i = 0; i < 300; i++) begin
      ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = ra;
      rs = 3'($urandom_range(0, 7));
      re = ($urandom_range(0, 9) != 0);
      step(ra, rb, rs, re);
      check($sformatf("rand%0d_sel%0d", i, rs), salida, model(ra, rb, rs, re));
    end

    // Output holds when inputs stay constant and no operation changes
    held = model(ra, rb, rs, re);
    @(posedge clk); #1;
    check("steady_hold", salida, held);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
